// File: rtl/if_id_skid_stage.sv
// -----------------------------------------------------------------------------
// if_id_skid_stage
//
// IF/ID pipeline stage for the J1-style stack CPU. Carries {pc, inst, T_m}
// from fetch to decode through a valid/ready handshake on both sides, backed
// by a 2-entry skid buffer (main register M, skid register S). Decode
// back-pressure never drops a fetched word, and a flush from EX empties the
// stage so decode sees a NOP bubble.
//
// Both handshake outputs come straight from state flops:
//   if_ready_o = ~S.valid, id_valid_o = M.valid.
//
// Optional feature (macro IF_ID_PERF_EN):
//   defined     -> saturating stall / flush performance counters are built.
//   not defined -> stall_cnt_o / flush_cnt_o are tied to 0, no counter flops.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   flush_i      in   jump/flush from EX, kills all buffered entries
//   if_valid_i   in   fetch presents a beat
//   if_ready_o   out  stage can accept a beat
//   pc_i         in   fetched pc            [ADDR_WIDTH]
//   inst_i       in   fetched instruction   [DATA_WIDTH]
//   T_m_i        in   fetched T_m word      [DATA_WIDTH]
//   id_valid_o   out  beat presented to decode
//   id_ready_i   in   decode accepts the beat
//   pc_o         out  pc to decode          [ADDR_WIDTH]
//   inst_o       out  instruction to decode [DATA_WIDTH]
//   T_m_o        out  T_m to decode         [DATA_WIDTH]
//   stall_cnt_o  out  stall cycles          [CNT_WIDTH]
//   flush_cnt_o  out  flush cycles          [CNT_WIDTH]
// -----------------------------------------------------------------------------
module if_id_skid_stage #(
  parameter int                    ADDR_WIDTH = 13,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] NOP_INST   = 16'h6000,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  if_valid_i,
  output logic                  if_ready_o,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] inst_i,
  input  logic [DATA_WIDTH-1:0] T_m_i,
  output logic                  id_valid_o,
  input  logic                  id_ready_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [DATA_WIDTH-1:0] T_m_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o,
  output logic [CNT_WIDTH-1:0]  flush_cnt_o
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] inst;
    logic [DATA_WIDTH-1:0] tm;
  } beat_t;

  // State encoding is {S.valid, M.valid}, so the valid bits are the state bits.
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'b00,
    ST_ONE     = 2'b01,
    ST_ILLEGAL = 2'b10,
    ST_FULL    = 2'b11
  } state_e;

  state_e r_state;
  beat_t  r_m;
  beat_t  r_s;

  logic  w_m_valid;
  logic  w_s_valid;
  logic  w_in_fire;
  logic  w_out_fire;
  logic  w_load_m_in;
  logic  w_load_m_s;
  logic  w_load_s_in;
  beat_t w_in;

  assign w_m_valid  = r_state[0];
  assign w_s_valid  = r_state[1];
  assign w_in_fire  = if_valid_i & ~w_s_valid;
  assign w_out_fire = w_m_valid & id_ready_i;
  assign w_in       = '{pc: pc_i, inst: inst_i, tm: T_m_i};

  // Data-path load enables; flush suppresses every load so a beat offered in
  // the flush cycle is dropped.
  assign w_load_m_in = ~flush_i & w_in_fire &
                       ((r_state == ST_EMPTY) | ((r_state == ST_ONE) & w_out_fire));
  assign w_load_s_in = ~flush_i & w_in_fire & (r_state == ST_ONE) & ~w_out_fire;
  assign w_load_m_s  = ~flush_i & w_out_fire & (r_state == ST_FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else if (flush_i) begin
      r_state <= ST_EMPTY;
    end else begin
      unique case (r_state)
        ST_EMPTY: if (w_in_fire) r_state <= ST_ONE;
        ST_ONE: begin
          if (w_in_fire && !w_out_fire)      r_state <= ST_FULL;
          else if (!w_in_fire && w_out_fire) r_state <= ST_EMPTY;
        end
        ST_FULL:  if (w_out_fire) r_state <= ST_ONE;
        default:  r_state <= ST_EMPTY;  // S valid without M: recover to empty
      endcase
    end
  end

  // NOTE: payload flops carry no reset; every consumer qualifies them with a
  // valid bit that is reset, so resetting the wide data path buys nothing.
  always_ff @(posedge clk) begin
    if (w_load_m_in)     r_m <= w_in;
    else if (w_load_m_s) r_m <= r_s;
    if (w_load_s_in)     r_s <= w_in;
  end

  assign if_ready_o = ~w_s_valid;
  assign id_valid_o = w_m_valid;
  assign pc_o       = w_m_valid ? r_m.pc   : '0;
  assign inst_o     = w_m_valid ? r_m.inst : NOP_INST;
  assign T_m_o      = w_m_valid ? r_m.tm   : '0;

`ifdef IF_ID_PERF_EN
  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic [CNT_WIDTH-1:0] r_flush_cnt;

  // Saturating counters: hold at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_m_valid && !id_ready_i && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (flush_i && (r_flush_cnt != '1))                  r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_if_id_skid_stage.sv
// -----------------------------------------------------------------------------
// tb_if_id_skid_stage
//
// Self-checking bench for if_id_skid_stage. A FIFO-of-beats reference model
// (capacity two, flush empties it) predicts every output each cycle. A table
// of hand-written vectors covers streaming, back-pressure, flush and
// simultaneous in/out; a random phase and an async-reset sequence follow.
// A second instance with CNT_WIDTH=2 exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_if_id_skid_stage;

  localparam int AW = 13;
  localparam int DW = 16;

`ifdef IF_ID_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush_i;
  logic          if_valid_i;
  logic          id_ready_i;
  logic [AW-1:0] pc_i;
  logic [DW-1:0] inst_i;
  logic [DW-1:0] T_m_i;

  logic          if_ready_o, id_valid_o;
  logic [AW-1:0] pc_o;
  logic [DW-1:0] inst_o, T_m_o;
  logic [15:0]   stall_cnt_o, flush_cnt_o;

  logic          sat_if_ready, sat_id_valid;
  logic [AW-1:0] sat_pc;
  logic [DW-1:0] sat_inst, sat_tm;
  logic [1:0]    sat_stall_cnt, sat_flush_cnt;

  always #5 clk = ~clk;

  if_id_skid_stage dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
    .pc_i(pc_i), .inst_i(inst_i), .T_m_i(T_m_i),
    .id_valid_o(id_valid_o), .id_ready_i(id_ready_i),
    .pc_o(pc_o), .inst_o(inst_o), .T_m_o(T_m_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  if_id_skid_stage #(.CNT_WIDTH(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .if_valid_i(if_valid_i), .if_ready_o(sat_if_ready),
    .pc_i(pc_i), .inst_i(inst_i), .T_m_i(T_m_i),
    .id_valid_o(sat_id_valid), .id_ready_i(id_ready_i),
    .pc_o(sat_pc), .inst_o(sat_inst), .T_m_o(sat_tm),
    .stall_cnt_o(sat_stall_cnt), .flush_cnt_o(sat_flush_cnt)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] inst;
    logic [DW-1:0] tm;
  } beat_t;

  beat_t       q[$];
  int unsigned m_stall;
  int unsigned m_flush;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic int unsigned sat(input int unsigned x, input int unsigned max);
    return (x > max) ? max : x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    beat_t h;
    bit    v;
    v = (q.size() > 0);
    h = v ? q[0] : '0;
    check({tag, " id_valid"}, 32'(id_valid_o), 32'(v));
    check({tag, " if_ready"}, 32'(if_ready_o), 32'(q.size() < 2));
    check({tag, " pc"},       32'(pc_o),       v ? 32'(h.pc)   : 32'h0);
    check({tag, " inst"},     32'(inst_o),     v ? 32'(h.inst) : 32'h6000);
    check({tag, " tm"},       32'(T_m_o),      v ? 32'(h.tm)   : 32'h0);
    check({tag, " sat_pc"},   32'(sat_pc),     v ? 32'(h.pc)   : 32'h0);
    check({tag, " stall_cnt"}, 32'(stall_cnt_o), PERF ? sat(m_stall, 16'hFFFF) : 0);
    check({tag, " flush_cnt"}, 32'(flush_cnt_o), PERF ? sat(m_flush, 16'hFFFF) : 0);
    check({tag, " sat_stall"}, 32'(sat_stall_cnt), PERF ? sat(m_stall, 3) : 0);
    check({tag, " sat_flush"}, 32'(sat_flush_cnt), PERF ? sat(m_flush, 3) : 0);
  endtask

  // Called at a falling edge: drive, advance one rising edge, update the
  // model, then compare at the next falling edge.
  task automatic step(input bit fl, input bit v, input bit r,
                      input logic [AW-1:0] pc, input logic [DW-1:0] inst,
                      input logic [DW-1:0] tm, input string tag);
    bit    in_f, out_f, stall;
    beat_t b;
    flush_i = fl; if_valid_i = v; id_ready_i = r;
    pc_i = pc; inst_i = inst; T_m_i = tm;
    in_f  = v && (q.size() < 2);
    out_f = (q.size() > 0) && r;
    stall = (q.size() > 0) && !r;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (out_f) void'(q.pop_front());
      if (in_f) begin
        b.pc = pc; b.inst = inst; b.tm = tm;
        q.push_back(b);
      end
    end
    if (stall) m_stall++;
    if (fl)    m_flush++;
    @(negedge clk);
    check_outputs(tag);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit            fl, v, r;
    logic [AW-1:0] pc;
    bit            e_idv, e_ifr;
    logic [AW-1:0] e_pc;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input bit fl, input bit v, input bit r, input int pc,
                         input bit e_idv, input bit e_ifr, input int e_pc);
    vec_t x;
    x.fl = fl; x.v = v; x.r = r; x.pc = AW'(pc);
    x.e_idv = e_idv; x.e_ifr = e_ifr; x.e_pc = AW'(e_pc);
    tbl.push_back(x);
  endtask

  function automatic logic [DW-1:0] inst_of(input logic [AW-1:0] pc);
    return 16'h8000 + DW'(pc);
  endfunction

  function automatic logic [DW-1:0] tm_of(input logic [AW-1:0] pc);
    return DW'(pc) ^ 16'h5A5A;
  endfunction

  initial begin
    // Streaming pc 0..7, then drain.
    for (int i = 0; i < 8; i++) add_vec(0, 1, 1, i, 1, 1, i);
    add_vec(0, 0, 1, 0, 0, 1, 0);
    // Back-pressure: M=3, pc 4 lands in S, pc 5 held upstream for 2 cycles.
    add_vec(0, 1, 1, 3, 1, 1, 3);
    add_vec(0, 1, 0, 4, 1, 0, 3);
    add_vec(0, 1, 0, 5, 1, 0, 3);
    add_vec(0, 1, 0, 5, 1, 0, 3);
    add_vec(0, 1, 1, 5, 1, 1, 4);
    add_vec(0, 1, 1, 5, 1, 1, 5);
    add_vec(0, 0, 1, 0, 0, 1, 0);
    // Flush in FULL with pc 12 offered, second consecutive flush, then pc 20.
    add_vec(0, 1, 0, 10, 1, 1, 10);
    add_vec(0, 1, 0, 11, 1, 0, 10);
    add_vec(1, 1, 0, 12, 0, 1, 0);
    add_vec(1, 1, 1, 13, 0, 1, 0);
    add_vec(0, 1, 1, 20, 1, 1, 20);
    add_vec(0, 0, 1, 0, 0, 1, 0);
    // Simultaneous in/out in ONE.
    add_vec(0, 1, 0, 5, 1, 1, 5);
    add_vec(0, 1, 1, 6, 1, 1, 6);
    add_vec(0, 0, 1, 0, 0, 1, 0);

    rst_n = 1'b0; flush_i = 0; if_valid_i = 0; id_ready_i = 0;
    pc_i = '0; inst_i = '0; T_m_i = '0;
    m_stall = 0; m_flush = 0;
    #12;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].fl, tbl[i].v, tbl[i].r, tbl[i].pc,
           inst_of(tbl[i].pc), tm_of(tbl[i].pc), $sformatf("vec%0d", i));
      check($sformatf("vec%0d hand id_valid", i), 32'(id_valid_o), 32'(tbl[i].e_idv));
      check($sformatf("vec%0d hand if_ready", i), 32'(if_ready_o), 32'(tbl[i].e_ifr));
      check($sformatf("vec%0d hand pc", i),       32'(pc_o),       32'(tbl[i].e_pc));
      check($sformatf("vec%0d hand inst", i),     32'(inst_o),
            tbl[i].e_idv ? 32'(inst_of(tbl[i].e_pc)) : 32'h6000);
    end

    // The table holds exactly 5 stall cycles and 2 flush cycles.
    check("table stall_cnt", 32'(stall_cnt_o),   PERF ? 32'd5 : 32'd0);
    check("table flush_cnt", 32'(flush_cnt_o),   PERF ? 32'd2 : 32'd0);
    check("table sat_stall", 32'(sat_stall_cnt), PERF ? 32'd3 : 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) != 0), AW'($urandom_range(0, 8191)),
           DW'($urandom), DW'($urandom), $sformatf("rnd%0d", i));
    end

    // Async reset while FULL, between clock edges.
    step(1, 0, 0, 0, 0, 0, "pre_rst_flush");
    step(0, 1, 0, 40, inst_of(40), tm_of(40), "pre_rst_m");
    step(0, 1, 0, 41, inst_of(41), tm_of(41), "pre_rst_s");
    check("full before reset if_ready", 32'(if_ready_o), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    q.delete(); m_stall = 0; m_flush = 0;
    check_outputs("async_rst");
    check("async_rst hand if_ready", 32'(if_ready_o), 32'd1);
    check("async_rst hand inst",     32'(inst_o),     32'h6000);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 1, 30, inst_of(30), tm_of(30), "post_rst");
    check("post_rst hand pc", 32'(pc_o), 32'd30);
    step(0, 0, 1, 0, 0, 0, "post_rst_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
